// File: rtl/proc_pkg.sv
// Shared definitions for the instruction fetch controller: state encoding and field widths.
package proc_pkg;

  localparam int OPCODE_W = 6;
  localparam int INSTR_W  = 16;

  localparam logic [OPCODE_W-1:0] HALT_OP_DEF = 6'h3F;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXEC    = 3'd3,
    S_WAIT_EX = 3'd4,
    S_HALT    = 3'd5,
    S_ERR     = 3'd6
  } state_t;

endpackage

// File: rtl/fetch_timer.sv
// Counts consecutive FETCH cycles without an acknowledge; flags the cycle the limit is reached.
module fetch_timer #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic count_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;

  // Any cycle that is not a waiting FETCH cycle restarts the run of misses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (count_i) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end

  assign expired_o = count_i && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch/decode/execute sequencer with retired-instruction counter.
// Optional fetch timeout is built in when FETCH_CTRL_TIMEOUT_EN is defined.
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | mem_req high until mem_ack
// DECODE  | one cycle, decode_vld high
// EXEC    | one cycle, exec_start high
// WAIT_EX | multi-cycle op, waiting for exec_done
// HALT    | halt opcode seen, terminal until rst
// ERR     | fetch timeout, terminal until rst
module fetch_ctrl import proc_pkg::*; #(
  parameter int unsigned          TIMEOUT_CYC = 15,
  parameter logic [OPCODE_W-1:0]  HALT_OP     = HALT_OP_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                mem_ack,
  input  logic [INSTR_W-1:0]  mem_rdata,
  input  logic                exec_done,
  output logic                mem_req,
  output logic                ir_en,
  output logic                pc_inc,
  output logic                decode_vld,
  output logic                exec_start,
  output logic [OPCODE_W-1:0] opcode,
  output logic [15:0]         instr_cnt,
  output logic [2:0]          state,
  output logic                halted,
  output logic                timeout_err
);

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] opcode_q;
  logic [15:0]         instr_cnt_q;
  logic                mem_req_q, decode_vld_q, exec_start_q, halted_q, timeout_err_q;
  logic                fetch_hit, fetch_wait, timeout_hit, retire;

  assign fetch_hit  = (state_q == S_FETCH) && mem_ack;
  assign fetch_wait = (state_q == S_FETCH) && !mem_ack;

`ifdef FETCH_CTRL_TIMEOUT_EN
  fetch_timer #(.LIMIT(TIMEOUT_CYC)) u_fetch_timer (
    .clk       (clk),
    .rst       (rst),
    .count_i   (fetch_wait),
    .expired_o (timeout_hit)
  );
`else
  logic unused_timeout;
  assign unused_timeout = fetch_wait ^ TIMEOUT_CYC[0];
  assign timeout_hit    = 1'b0;
`endif

  logic unused_rdata;
  assign unused_rdata = ^mem_rdata[INSTR_W-OPCODE_W-1:0];

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_IDLE:    if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ack)          state_d = S_DECODE;
        else if (timeout_hit) state_d = S_ERR;
      end
      S_DECODE:  state_d = (opcode_q == HALT_OP) ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (opcode_q[OPCODE_W-1]) begin
          state_d = S_WAIT_EX;
        end else begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_WAIT_EX: begin
        if (exec_done) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_HALT:    state_d = S_HALT;
      S_ERR:     state_d = S_ERR;
      default:   state_d = S_IDLE;
    endcase
  end

  // Moore outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      opcode_q      <= '0;
      instr_cnt_q   <= '0;
      mem_req_q     <= 1'b0;
      decode_vld_q  <= 1'b0;
      exec_start_q  <= 1'b0;
      halted_q      <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= (state_d == S_FETCH);
      decode_vld_q <= (state_d == S_DECODE);
      exec_start_q <= (state_d == S_EXEC);
      halted_q     <= (state_d == S_HALT);
      if (fetch_hit)   opcode_q      <= mem_rdata[INSTR_W-1:INSTR_W-OPCODE_W];
      if (retire)      instr_cnt_q   <= instr_cnt_q + 1'b1;
      if (timeout_hit) timeout_err_q <= 1'b1;
    end
  end

  assign ir_en       = fetch_hit;
  assign pc_inc      = fetch_hit;
  assign mem_req     = mem_req_q;
  assign decode_vld  = decode_vld_q;
  assign exec_start  = exec_start_q;
  assign opcode      = opcode_q;
  assign instr_cnt   = instr_cnt_q;
  assign state       = state_q;
  assign halted      = halted_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 15, meaning the number of FETCH cycles without mem_ack before an error (used only with FETCH_CTRL_TIMEOUT_EN).
REQ-002 SHALL have parameter HALT_OP, default 6'h3F, meaning the opcode that enters HALT.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port start, input, 1 bit: leave IDLE and begin fetching.
REQ-006 SHALL have port mem_ack, input, 1 bit: mem_rdata is valid this cycle.
REQ-007 SHALL have port mem_rdata, input, 16 bits: instruction word from memory.
REQ-008 SHALL have port exec_done, input, 1 bit: datapath has finished a multi-cycle operation.
REQ-009 SHALL have port mem_req, output, 1 bit: instruction read request.
REQ-010 SHALL have port ir_en, output, 1 bit: load enable for the instruction register.
REQ-011 SHALL have port pc_inc, output, 1 bit: program counter increment strobe.
REQ-012 SHALL have port decode_vld, output, 1 bit: opcode is valid for decode.
REQ-013 SHALL have port exec_start, output, 1 bit: one-cycle execute strobe.
REQ-014 SHALL have port opcode, output, 6 bits: latched mem_rdata[15:10].
REQ-015 SHALL have port instr_cnt, output, 16 bits: count of retired instructions.
REQ-016 SHALL have port state, output, 3 bits: current FSM state code.
REQ-017 SHALL have port halted, output, 1 bit: high while in HALT.
REQ-018 SHALL have port timeout_err, output, 1 bit: sticky fetch-timeout flag.

Function
REQ-019 SHALL implement FSM states IDLE=0, FETCH=1, DECODE=2, EXEC=3, WAIT_EX=4, HALT=5, ERR=6; all outputs SHALL be Moore except ir_en and pc_inc.
REQ-020 In IDLE, all strobes SHALL be 0; start=1 SHALL move the FSM to FETCH on the next edge.
REQ-021 In FETCH, mem_req SHALL be 1; while mem_ack=0 the FSM SHALL stay in FETCH.
REQ-022 In FETCH with mem_ack=1, ir_en=1 and pc_inc=1 SHALL be asserted combinationally in that same cycle (the IR bypass exposes the word immediately), opcode SHALL latch mem_rdata[15:10], and the next state SHALL be DECODE.
REQ-023 mem_ack outside FETCH SHALL be ignored: no ir_en, no pc_inc, no opcode change.
REQ-024 DECODE SHALL last exactly 1 cycle with decode_vld=1; next state SHALL be HALT if opcode==HALT_OP, else EXEC.
REQ-025 EXEC SHALL last exactly 1 cycle with exec_start=1; next state SHALL be FETCH if opcode[5]=0, else WAIT_EX.
REQ-026 WAIT_EX SHALL hold until exec_done=1, then go to FETCH; exec_done SHALL be sampled only in WAIT_EX.
REQ-027 instr_cnt SHALL increment by 1 on leaving EXEC toward FETCH and on leaving WAIT_EX; it SHALL wrap from 0xFFFF to 0x0000.
REQ-028 HALT SHALL be terminal until rst; halted=1, mem_req=0, and start SHALL be ignored.
REQ-029 Minimum fetch-to-fetch latency for a single-cycle op with immediate ack SHALL be 3 cycles (FETCH, DECODE, EXEC).

Reset
REQ-030 While rst=1, the FSM SHALL be in IDLE; opcode=0, instr_cnt=0, timeout counter=0, timeout_err=0, and all strobes, halted and mem_req SHALL be 0, independent of clk.
REQ-031 rst asserted mid-operation, including during a pending FETCH or WAIT_EX, SHALL abort immediately with no completion strobe.

Configuration
REQ-032 With macro FETCH_CTRL_TIMEOUT_EN defined, a counter SHALL count consecutive FETCH cycles with mem_ack=0 and reset on leaving FETCH.
REQ-033 With the macro defined, when the counter reaches TIMEOUT_CYC the FSM SHALL go to ERR, with timeout_err=1 sticky until rst and mem_req=0.
REQ-034 With the macro defined, mem_ack=1 on the cycle the limit is reached SHALL win: a normal fetch, no error.
REQ-035 Without the macro, FETCH SHALL wait indefinitely, timeout_err SHALL be tied to 0, and ERR SHALL be unreachable.

Structure
REQ-036 Shared package proc_pkg SHALL hold the state encoding, OPCODE_W=6, INSTR_W=16 and the default HALT_OP.
REQ-037 The timeout counter SHALL be sub-module fetch_timer, instantiated only under FETCH_CTRL_TIMEOUT_EN.

Verification
REQ-038 rst, then start=1, mem_ack in the first FETCH cycle with mem_rdata=16'h0400 -> ir_en=pc_inc=1 that cycle, opcode=6'h01, exec_start 2 cycles later, instr_cnt=1.
REQ-039 mem_rdata=16'h8000 (opcode 6'h20) -> WAIT_EX held for 5 cycles until exec_done=1, then FETCH; no instr_cnt change before exec_done.
REQ-040 mem_rdata=16'hFC00 -> DECODE then HALT, halted=1, mem_req=0; a later start pulse SHALL leave state=5.
REQ-041 With macro, mem_ack withheld for 15 FETCH cycles -> state=6, timeout_err=1; ack on the 15th cycle instead -> DECODE, timeout_err=0.
REQ-042 Preload 0xFFFF retired instructions (force) plus one more -> instr_cnt=0x0000; rst asserted in WAIT_EX -> state=0, all outputs 0 asynchronously.
